// File: rtl/tx_queue_scheduler.sv
// Four-queue tx scheduler: arbitrates round-robin or strict priority, holds the grant
// through the PHY start/done handshake, then enforces an inter-packet gap.
module tx_queue_scheduler #(
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count0,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count1,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count2,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count3,
    input  logic [3:0]                        queue_enable,
    input  logic                              prio_mode,
    input  logic [15:0]                       req_timeout,
    input  logic [7:0]                        ifs_gap,
    input  logic                              phy_tx_started,
    input  logic                              phy_tx_done,
    output logic [1:0]                        tx_queue_idx,
    output logic                              tx_req,
    output logic                              sched_busy,
    output logic                              timeout_pulse,
    output logic [15:0]                       pkt_sent_count
);

    typedef enum logic [1:0] {IDLE, REQ, BUSY, GAP} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  rr_ptr;
    logic [1:0]  rr_ptr_next;
    logic [1:0]  idx_next;
    logic [1:0]  winner;
    logic [1:0]  cand;
    logic [15:0] tmo_cnt;
    logic [15:0] tmo_cnt_next;
    logic [15:0] tmo_len;
    logic [15:0] tmo_len_next;
    logic [7:0]  gap_cnt;
    logic [7:0]  gap_cnt_next;
    logic [7:0]  gap_len;
    logic [7:0]  gap_len_next;
    logic [15:0] pkt_cnt_next;
    logic        pulse_next;
    logic [3:0]  eligible;
    logic        any_eligible;

    assign eligible = queue_enable & {data_count3 != '0, data_count2 != '0,
                                      data_count1 != '0, data_count0 != '0};
    assign any_eligible = |eligible;

    // Later loop iterations override earlier ones, so the scan order picks the winner.
    always_comb begin
        winner = rr_ptr;
        cand   = rr_ptr;
        if (prio_mode) begin
            for (int i = 0; i < 4; i++) begin
                if (eligible[i]) winner = 2'(i);
            end
        end else begin
            for (int k = 3; k >= 0; k--) begin
                cand = rr_ptr + 2'(k);
                if (eligible[cand]) winner = cand;
            end
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = tx_queue_idx;
        rr_ptr_next  = rr_ptr;
        tmo_cnt_next = tmo_cnt;
        tmo_len_next = tmo_len;
        gap_cnt_next = gap_cnt;
        gap_len_next = gap_len;
        pkt_cnt_next = pkt_sent_count;
        pulse_next   = 1'b0;
        case (state)
            IDLE: begin
                if (any_eligible) begin
                    idx_next     = winner;
                    tmo_cnt_next = '0;
                    tmo_len_next = req_timeout;
                    state_next   = REQ;
                end
            end
            REQ: begin
                tmo_cnt_next = tmo_cnt + 16'd1;
                // Started beats both a queue disable and a timeout in the same cycle.
                if (phy_tx_started) begin
                    state_next = BUSY;
                end else if (!queue_enable[tx_queue_idx]) begin
                    state_next = IDLE;
                end else if (tmo_len != '0 && tmo_cnt == tmo_len - 16'd1) begin
                    state_next  = IDLE;
                    pulse_next  = 1'b1;
                    rr_ptr_next = tx_queue_idx + 2'd1;
                end
            end
            BUSY: begin
                if (phy_tx_done) begin
                    rr_ptr_next  = tx_queue_idx + 2'd1;
                    pkt_cnt_next = pkt_sent_count + 16'd1;
                    if (ifs_gap != '0) begin
                        state_next   = GAP;
                        gap_cnt_next = '0;
                        gap_len_next = ifs_gap;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == gap_len - 8'd1) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx_req and sched_busy are registered from the next state so they align with it.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state          <= IDLE;
            tx_queue_idx   <= '0;
            rr_ptr         <= '0;
            tmo_cnt        <= '0;
            tmo_len        <= '0;
            gap_cnt        <= '0;
            gap_len        <= '0;
            pkt_sent_count <= '0;
            timeout_pulse  <= 1'b0;
            tx_req         <= 1'b0;
            sched_busy     <= 1'b0;
        end else begin
            state          <= state_next;
            tx_queue_idx   <= idx_next;
            rr_ptr         <= rr_ptr_next;
            tmo_cnt        <= tmo_cnt_next;
            tmo_len        <= tmo_len_next;
            gap_cnt        <= gap_cnt_next;
            gap_len        <= gap_len_next;
            pkt_sent_count <= pkt_cnt_next;
            timeout_pulse  <= pulse_next;
            tx_req         <= (state_next == REQ);
            sched_busy     <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_tx_queue_scheduler.sv
// Self-checking bench for tx_queue_scheduler: directed scenarios with literal
// expectations, then random traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_tx_queue_scheduler;

    localparam int W = 14;
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_BUSY = 2;
    localparam int P_GAP  = 3;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic [W-1:0] dc0     = '0;
    logic [W-1:0] dc1     = '0;
    logic [W-1:0] dc2     = '0;
    logic [W-1:0] dc3     = '0;
    logic [3:0]   q_en    = '0;
    logic         prio    = 1'b0;
    logic [15:0]  tmo     = '0;
    logic [7:0]   gap     = '0;
    logic         started = 1'b0;
    logic         done    = 1'b0;
    logic [1:0]   idx;
    logic         req;
    logic         busy;
    logic         tpulse;
    logic [15:0]  cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model: grant owner, countdowns and a packet tally.
    int       m_phase     = P_IDLE;
    int       m_idx       = 0;
    int       m_rr        = 0;
    int       m_req_left  = 0;
    bit       m_tmo_armed = 1'b0;
    int       m_gap_left  = 0;
    int       m_pulse     = 0;
    int       m_count     = 0;
    int       m_w         = -1;
    logic [3:0] m_elig    = '0;

    always #5 clk = ~clk;

    tx_queue_scheduler #(.MAX_BIT_NUM_DMA_SYMBOL(W)) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .data_count0    (dc0),
        .data_count1    (dc1),
        .data_count2    (dc2),
        .data_count3    (dc3),
        .queue_enable   (q_en),
        .prio_mode      (prio),
        .req_timeout    (tmo),
        .ifs_gap        (gap),
        .phy_tx_started (started),
        .phy_tx_done    (done),
        .tx_queue_idx   (idx),
        .tx_req         (req),
        .sched_busy     (busy),
        .timeout_pulse  (tpulse),
        .pkt_sent_count (cnt)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int pickQueue(input logic [3:0] elig, input bit strict, input int rr);
        int w = -1;
        int j;
        if (strict) begin
            for (int q = 0; q < 4; q++) begin
                if (elig[q]) w = q;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                j = (rr + k) % 4;
                if (w < 0 && elig[j[1:0]]) w = j;
            end
        end
        return w;
    endfunction

    initial begin : model_proc
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = P_IDLE; m_idx = 0; m_rr = 0; m_pulse = 0; m_count = 0;
                m_req_left = 0; m_gap_left = 0; m_tmo_armed = 1'b0;
            end else begin
                m_pulse = 0;
                case (m_phase)
                    P_IDLE: begin
                        m_elig = q_en & {dc3 != '0, dc2 != '0, dc1 != '0, dc0 != '0};
                        m_w = pickQueue(m_elig, prio, m_rr);
                        if (m_w >= 0) begin
                            m_idx       = m_w;
                            m_phase     = P_REQ;
                            m_tmo_armed = (tmo != '0);
                            m_req_left  = int'(tmo);
                        end
                    end
                    P_REQ: begin
                        if (started) begin
                            m_phase = P_BUSY;
                        end else if (!q_en[m_idx[1:0]]) begin
                            m_phase = P_IDLE;
                        end else if (m_tmo_armed) begin
                            m_req_left--;
                            if (m_req_left == 0) begin
                                m_phase = P_IDLE;
                                m_pulse = 1;
                                m_rr    = (m_idx + 1) % 4;
                            end
                        end
                    end
                    P_BUSY: begin
                        if (done) begin
                            m_rr    = (m_idx + 1) % 4;
                            m_count = (m_count + 1) % 65536;
                            if (gap != '0) begin
                                m_phase    = P_GAP;
                                m_gap_left = int'(gap);
                            end else begin
                                m_phase = P_IDLE;
                            end
                        end
                    end
                    default: begin
                        m_gap_left--;
                        if (m_gap_left == 0) m_phase = P_IDLE;
                    end
                endcase
            end
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            checkOutput("model_idx", int'(idx), m_idx);
            checkOutput("model_tx_req", int'(req), (m_phase == P_REQ) ? 1 : 0);
            checkOutput("model_busy", int'(busy), (m_phase != P_IDLE) ? 1 : 0);
            checkOutput("model_timeout_pulse", int'(tpulse), m_pulse);
            checkOutput("model_count", int'(cnt), m_count);
        end
    end

    task automatic applyStimulus(input int c0, input int c1, input int c2, input int c3,
                                 input logic [3:0] en, input bit p, input int t, input int g);
        dc0  = W'(c0);
        dc1  = W'(c1);
        dc2  = W'(c2);
        dc3  = W'(c3);
        q_en = en;
        prio = p;
        tmo  = 16'(t);
        gap  = 8'(g);
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, (req === 1'b1) ? 1 : 0, 1);
    endtask

    task automatic finishGrant();
        started = 1'b1;
        @(negedge clk);
        started = 1'b0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic doneToReq(input bit inject, output int cycles);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        cycles = 1;
        while (req !== 1'b1 && cycles < 50) begin
            if (inject && cycles == 2) begin
                started = 1'b1;
                done    = 1'b1;
            end else begin
                started = 1'b0;
                done    = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        started = 1'b0;
        done    = 1'b0;
    endtask

    task automatic doReset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin : stim_proc
        int cyc;
        int high;

        repeat (3) @(negedge clk);
        checkOutput("reset_idx", int'(idx), 0);
        checkOutput("reset_req", int'(req), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_pulse", int'(tpulse), 0);
        checkOutput("reset_count", int'(cnt), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single nonempty queue, then rr pointer observed through the next grant.
        applyStimulus(0, 5, 0, 0, 4'hF, 1'b0, 0, 0);
        @(negedge clk);
        checkOutput("t1_idx", int'(idx), 1);
        checkOutput("t1_req", int'(req), 1);
        started = 1'b1;
        @(negedge clk);
        started = 1'b0;
        checkOutput("t1_req_after_start", int'(req), 0);
        checkOutput("t1_busy", int'(busy), 1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        applyStimulus(5, 5, 5, 5, 4'hF, 1'b0, 0, 0);
        checkOutput("t1_count", int'(cnt), 1);
        checkOutput("t1_idle", int'(busy), 0);
        @(negedge clk);
        checkOutput("t1_next_idx_rr2", int'(idx), 2);
        checkOutput("t1_next_req", int'(req), 1);

        // Round-robin order and done-to-request latency with no gap.
        doReset();
        for (int g = 0; g < 5; g++) begin
            waitReq("t2_wait_req");
            checkOutput("t2_grant_order", int'(idx), g % 4);
            started = 1'b1;
            @(negedge clk);
            started = 1'b0;
            @(negedge clk);
            doneToReq(1'b0, cyc);
            checkOutput("t2_done_to_req", cyc, 2);
        end

        // Strict priority.
        applyStimulus(5, 5, 5, 5, 4'hF, 1'b1, 0, 0);
        finishGrant();
        waitReq("t3_wait_req_a");
        checkOutput("t3_strict_q3_a", int'(idx), 3);
        finishGrant();
        waitReq("t3_wait_req_b");
        checkOutput("t3_strict_q3_b", int'(idx), 3);
        finishGrant();
        applyStimulus(5, 5, 5, 0, 4'hF, 1'b1, 0, 0);
        waitReq("t3_wait_req_c");
        checkOutput("t3_strict_q2", int'(idx), 2);

        // Request timeout.
        finishGrant();
        applyStimulus(5, 5, 5, 5, 4'hF, 1'b0, 10, 0);
        waitReq("t4_wait_req");
        checkOutput("t4_idx", int'(idx), 3);
        high = 0;
        while (req === 1'b1 && high < 40) begin
            high++;
            @(negedge clk);
        end
        checkOutput("t4_req_high_cycles", high, 10);
        checkOutput("t4_timeout_pulse", int'(tpulse), 1);
        applyStimulus(5, 5, 5, 5, 4'hF, 1'b0, 0, 0);
        @(negedge clk);
        checkOutput("t4_pulse_one_cycle", int'(tpulse), 0);
        checkOutput("t4_next_grant", int'(idx), 0);
        checkOutput("t4_next_req", int'(req), 1);

        // Inter-packet gap with stray pulses injected during it.
        applyStimulus(5, 5, 5, 5, 4'hF, 1'b0, 0, 4);
        started = 1'b1;
        @(negedge clk);
        started = 1'b0;
        @(negedge clk);
        doneToReq(1'b1, cyc);
        checkOutput("t5_done_to_req_gap4", cyc, 6);
        checkOutput("t5_count", int'(cnt), 10);
        checkOutput("t5_idx", int'(idx), 1);

        // Asynchronous reset in BUSY.
        started = 1'b1;
        @(negedge clk);
        started = 1'b0;
        checkOutput("t6_busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_idx", int'(idx), 0);
        checkOutput("t6_async_req", int'(req), 0);
        checkOutput("t6_async_busy", int'(busy), 0);
        checkOutput("t6_async_pulse", int'(tpulse), 0);
        checkOutput("t6_async_count", int'(cnt), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_restart_idx", int'(idx), 0);
        checkOutput("t6_restart_req", int'(req), 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                dc0  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 16383));
                dc1  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 16383));
                dc2  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 16383));
                dc3  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 16383));
                q_en = 4'($urandom);
                prio = 1'($urandom_range(0, 1));
                tmo  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
                gap  = 8'($urandom_range(0, 4));
            end
            started = ((req === 1'b1) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 30) == 0);
            done    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        started = 1'b0;
        done    = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_queue_scheduler.md
# tx_queue_scheduler

Selects which of the four tx queue FIFOs feeds the tx datapath next and holds that selection for one whole packet. It watches per-queue fill levels (`data_count0..3`) and enable masks, arbitrates round-robin or strict-priority, and drives `tx_queue_idx` into the FIFO read mux. It handshakes with the PHY-side start/done pulses and enforces an inter-packet gap.

## Interface
- MAX_BIT_NUM_DMA_SYMBOL, 14, width of the per-queue data counts
- S_AXIS_ACLK  in  1  clock; all logic on the rising edge
- S_AXIS_ARESETN  in  1  reset; asynchronous, active-low
- data_count0..data_count3  in  MAX_BIT_NUM_DMA_SYMBOL each  FIFO read data counts (queue i)
- queue_enable  in  4  per-queue enable mask; bit i gates queue i
- prio_mode  in  1  0 = round-robin, 1 = strict priority (queue 3 highest)
- req_timeout  in  16  max REQ cycles; 0 = no timeout
- ifs_gap  in  8  post-packet gap cycles; 0 = no gap
- phy_tx_started  in  1  one-cycle pulse: PHY began reading the granted queue
- phy_tx_done  in  1  one-cycle pulse: PHY finished the packet
- tx_queue_idx  out  2  selected queue, registered
- tx_req  out  1  request to PHY to start tx from `tx_queue_idx`
- sched_busy  out  1  high in every state except IDLE
- timeout_pulse  out  1  one-cycle pulse when a REQ times out
- pkt_sent_count  out  16  wrapping count of completed packets

## Operation
- eligible[i] = queue_enable[i] && (data_count_i != 0). This is combinational and sampled only in IDLE.
- Winner in round-robin mode: the first eligible index scanning rr_ptr, rr_ptr+1, … mod 4.
- Winner in strict mode: the highest eligible index. rr_ptr is ignored but still updated.
- States: IDLE, REQ, BUSY, GAP.
- IDLE: if any eligible, register tx_queue_idx <= winner and go to REQ. Otherwise stay. tx_queue_idx keeps its last value.
- REQ: tx_req=1, and the timeout counter increments each cycle.
  - phy_tx_started → BUSY.
  - Else, if queue_enable[tx_queue_idx]==0 → IDLE with no pulse.
  - Else, if req_timeout!=0 and the counter reaches req_timeout-1 → IDLE, timeout_pulse=1, rr_ptr <= tx_queue_idx+1.
  - phy_tx_done in REQ is ignored.
- BUSY: tx_req=0. On phy_tx_done: rr_ptr <= tx_queue_idx+1 (mod 4), pkt_sent_count += 1, then go to GAP if ifs_gap!=0, else IDLE.
- GAP: gap counter runs ifs_gap cycles exactly, then IDLE. Pulses on the PHY inputs are ignored.
- Counters clear on every entry to REQ or GAP. The timeout counter is 16 bits and the gap counter is 8 bits. req_timeout and ifs_gap are sampled on entry and held.
- Reset values: state IDLE, tx_queue_idx=0, tx_req=0, sched_busy=0, timeout_pulse=0, pkt_sent_count=0, rr_ptr=0.
- A reset in any state returns everything to reset values immediately, with no completion and no count.

## Timing
- Eligibility to request latency: eligible at cycle N in IDLE gives tx_queue_idx valid and tx_req=1 from cycle N+1.
- tx_queue_idx is stable from REQ entry until the cycle after leaving BUSY/GAP. It never changes while tx_req=1 or in BUSY.
- tx_req deasserts in the cycle after phy_tx_started is sampled.
- If phy_tx_started and the timeout condition occur in the same cycle, started wins: no timeout_pulse.
- If queue disable and phy_tx_started occur in the same cycle, started wins.
- phy_tx_done then next grant:
  - With ifs_gap=G>0: done sampled at cycle N, GAP covers N+1..N+G, IDLE at N+G+1, next tx_req at N+G+2.
  - With G=0: IDLE at N+1, tx_req at N+2.
- After a timeout, IDLE is reached the next cycle, and rearbitration takes a further cycle.
- pkt_sent_count wraps from 0xFFFF to 0.
- sched_busy is registered together with the state.

## Test plan
- Reset, then data_count1=5 with all queues enabled, round-robin: tx_queue_idx=1 and tx_req=1 one cycle later. Pulse started, then done: pkt_sent_count=1 and rr_ptr=2.
- All four queues nonempty, round-robin, ifs_gap=0, started/done pulses for every grant: grant order 0,1,2,3,0. Each tx_req rises exactly 2 cycles after the preceding done.
- Same fill, prio_mode=1: queue 3 granted repeatedly. Set data_count3=0: queue 2 granted next.
- req_timeout=10, no started pulse: tx_req is high for exactly 10 cycles, then timeout_pulse for 1 cycle and tx_req low. The next grant goes to the following eligible queue.
- ifs_gap=4 with continuous eligibility: tx_req rises 6 cycles after the done pulse. A done or started pulse injected during GAP has no effect.
- Deassert S_AXIS_ARESETN mid-BUSY: all outputs go to zero asynchronously and pkt_sent_count=0. After release, arbitration restarts from queue 0.
